serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
Parametrised digit-serial adder/subtractor. It trades area for latency by processing DIGIT bits per clock, least-significant digit first, over a start/done handshake. It succeeds the flat combinational ripple adder. It adds a subtract mode, a signed-overflow flag and a registered, stable result, and it serves datapaths where a WIDTH-bit adder per lane is too costly.

Parameters:
WIDTH, 16, operand/result width in bits; must be a positive multiple of DIGIT.
DIGIT, 4, bits processed per clock; N = WIDTH/DIGIT cycles per operation.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-high reset.
start  in  1  request; sampled only when state is IDLE or DONE.
a  in  WIDTH  operand A; captured on the accepting edge.
b  in  WIDTH  operand B; captured on the accepting edge.
cin  in  1  carry-in (add) / borrow-in (sub); captured on the accepting edge.
sub  in  1  0: a+b+cin; 1: a-b-cin; captured on the accepting edge.
busy  out  1  high while state is RUN.
done  out  1  one-cycle pulse; the result is valid from this cycle onward.
sum  out  WIDTH  registered result; changes only when done rises.
co  out  1  carry-out (add) / NOT borrow-out (sub).
ovf  out  1  two's-complement overflow of the result.

Behaviour:
- States: IDLE, RUN, DONE.
  - IDLE: start=1 goes to RUN; otherwise stays in IDLE.
  - RUN: goes to DONE after digit N-1; otherwise stays in RUN.
  - DONE: start=1 goes to RUN; otherwise returns to IDLE.
- Accepting edge (start=1 in IDLE/DONE):
  - opA <= a;
  - opB <= sub ? ~b : b;
  - carry <= sub ? ~cin : cin;
  - digit index <= 0.
- Each RUN edge:
  - One DIGIT-wide add of opA[DIGIT-1:0] + opB[DIGIT-1:0] + carry.
  - The digit result is shifted into the partial-result register from the MSB side.
  - opA and opB shift right by DIGIT; carry <= digit carry-out; index increments.
- Final RUN edge (index N-1):
  - sum <= completed partial result; co <= final carry.
  - ovf <= (carry into bit WIDTH-1) XOR (carry out of bit WIDTH-1). The slice therefore also reports the carry into its MSB.
  - done <= 1.
- Latency: done rises exactly N edges after the accepting edge. Back-to-back throughput is one result per N+1 cycles, because start is accepted in DONE.
- start in RUN is ignored. No queuing and no error flag.
- a, b, cin and sub may change freely after the accepting edge.
- sum, co and ovf hold their last completed values until the next done. Intermediate partial results are never visible on the sum port.
- Width rules:
  - Internal carry is 1 bit.
  - {co,sum} equals the (WIDTH+1)-bit true sum for add.
  - For sub, sum = (a-b-cin) mod 2^WIDTH, and co=0 indicates a borrow.
- N=1 (WIDTH==DIGIT) is legal: a single RUN cycle, then DONE.
- Reset (async, any state, including mid-RUN):
  - state=IDLE; busy=0; done=0; sum=0; co=0; ovf=0.
  - All operand, partial and index registers are cleared; an in-flight operation is discarded.
- Reset release: the first start is accepted on the first rising edge with rst=0 and start=1.

Decomposition:
- Shared package:
  - state enum {IDLE, RUN, DONE};
  - localparam function computing N and the index width $clog2(N) (minimum 1).
- Elaboration-time check in the package or top: WIDTH % DIGIT == 0.
- One natural sub-module, adder_slice #(DIGIT):
  - combinational; inputs x, y, ci;
  - outputs s, co, and c_msb_in (carry into bit DIGIT-1).
- Top-level serial_adder holds the FSM, shift registers and output registers.

Test Plan (WIDTH=16, DIGIT=4 unless stated; all checks in the done cycle):
- a=16'h00FF, b=16'h0001, cin=0, sub=0 -> done exactly 4 edges after acceptance; sum=16'h0100, co=0, ovf=0; busy high for 4 cycles.
- a=16'hFFFF, b=16'h0001, cin=0, add -> sum=16'h0000, co=1, ovf=0. a=16'h7FFF, b=16'h0001 -> sum=16'h8000, co=0, ovf=1.
- Subtract mode:
  - sub=1, a=16'h0005, b=16'h0007, cin=0 -> sum=16'hFFFE, co=0, ovf=0.
  - a=16'h8000, b=16'h0001 -> sum=16'h7FFF, co=1, ovf=1.
  - a=16'h0005, b=16'h0002, cin=1 -> sum=16'h0002, co=1.
- Handshake:
  - start held high continuously -> done pulses every 5 cycles; start toggled in RUN is ignored.
  - Change a/b during RUN -> result unaffected.
  - sum stays stable between done pulses.
- Reset at the 2nd RUN cycle -> same cycle: busy=0, done=0, sum=0, co=0, ovf=0. A subsequent a=16'h1234, b=16'h1111 completes with sum=16'h2345.
- Exhaustive sweep at WIDTH=4, DIGIT=1 and WIDTH=4, DIGIT=4:
  - all a, b, cin, sub;
  - {co,sum} matches the reference model; ovf matches the sign-bit rule;
  - latency is N in every case.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the digit-serial adder/subtractor: FSM state type and
// elaboration-time sizing helpers.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int digit_count(input int width, input int digit);
        return width / digit;
    endfunction

    // A single-digit operation still needs a 1-bit index register.
    function automatic int index_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Start/done request bus of the serial adder, with the operand and result fields.
interface serial_adder_if #(
    parameter int WIDTH = 16
) ();
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             co;
    logic             ovf;

    modport master (
        output start, a, b, cin, sub,
        input  busy, done, sum, co, ovf
    );

    modport slave (
        input  start, a, b, cin, sub,
        output busy, done, sum, co, ovf
    );
endinterface

// File: rtl/serial_adder_slice.sv
// One DIGIT-wide combinational adder slice; also reports the carry into its MSB
// so the top level can derive signed overflow on the last digit.
module adder_slice #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             ci,
    output logic [DIGIT-1:0] s,
    output logic             co,
    output logic             c_msb_in
);
    logic [DIGIT:0] total_s;

    assign total_s  = {1'b0, x} + {1'b0, y} + {{DIGIT{1'b0}}, ci};
    assign s        = total_s[DIGIT-1:0];
    assign co       = total_s[DIGIT];
    // Sum bit = x ^ y ^ carry-in, so the MSB carry-in falls out without a second adder.
    assign c_msb_in = s[DIGIT-1] ^ x[DIGIT-1] ^ y[DIGIT-1];
endmodule

// File: rtl/serial_adder.sv
// Digit-serial adder/subtractor: LSD first, DIGIT bits per clock, with a
// registered result that only changes on the done pulse.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic           clk,
    input  logic           rst,
    serial_adder_if.slave  bus
);
    localparam int N    = digit_count(WIDTH, DIGIT);
    localparam int IDXW = index_width(N);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

    generate
        if ((DIGIT <= 0) || (WIDTH <= 0) || ((WIDTH % DIGIT) != 0)) begin : g_bad_params
            $error("serial_adder: WIDTH must be a positive multiple of DIGIT");
        end
    endgenerate

    state_t            state_r;
    state_t            state_next_s;
    logic [WIDTH-1:0]  opa_r;
    logic [WIDTH-1:0]  opb_r;
    logic              carry_r;
    logic [IDXW-1:0]   idx_r;
    logic [WIDTH-1:0]  part_next_s;
    logic [WIDTH-1:0]  sum_r;
    logic              co_r;
    logic              ovf_r;
    logic              done_r;
    logic              busy_r;
    logic [DIGIT-1:0]  slice_s_s;
    logic              slice_co_s;
    logic              slice_cmsb_s;
    logic              accept_s;
    logic              last_s;

    assign accept_s = bus.start && ((state_r == IDLE) || (state_r == DONE));
    assign last_s   = (state_r == RUN) && (idx_r == LAST_IDX);

    adder_slice #(.DIGIT(DIGIT)) u_slice (
        .x        (opa_r[DIGIT-1:0]),
        .y        (opb_r[DIGIT-1:0]),
        .ci       (carry_r),
        .s        (slice_s_s),
        .co       (slice_co_s),
        .c_msb_in (slice_cmsb_s)
    );

    // The partial register only needs the WIDTH-DIGIT bits already produced;
    // the current digit is joined on the fly, so N==1 needs no partial register.
    generate
        if (N == 1) begin : g_single
            assign part_next_s = slice_s_s;
        end else begin : g_multi
            logic [WIDTH-DIGIT-1:0] part_r;

            assign part_next_s = {slice_s_s, part_r};

            // Partial-result shift register, filled from the MSB side.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    part_r <= '0;
                end else if (accept_s) begin
                    part_r <= '0;
                end else if (state_r == RUN) begin
                    part_r <= part_next_s[WIDTH-1:DIGIT];
                end else begin
                    part_r <= part_r;
                end
            end
        end
    endgenerate

    // FSM next-state decode.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.start) state_next_s = RUN;
                else           state_next_s = IDLE;
            end
            RUN: begin
                if (idx_r == LAST_IDX) state_next_s = DONE;
                else                   state_next_s = RUN;
            end
            DONE: begin
                if (bus.start) state_next_s = RUN;
                else           state_next_s = IDLE;
            end
            default: state_next_s = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_r <= IDLE;
        else     state_r <= state_next_s;
    end

    // Operand shift registers, running carry and digit index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opa_r   <= '0;
            opb_r   <= '0;
            carry_r <= 1'b0;
            idx_r   <= '0;
        end else if (accept_s) begin
            // Subtraction is a + ~b + ~cin, so co reads as NOT borrow.
            opa_r   <= bus.a;
            opb_r   <= bus.sub ? ~bus.b : bus.b;
            carry_r <= bus.sub ^ bus.cin;
            idx_r   <= '0;
        end else if (state_r == RUN) begin
            opa_r   <= opa_r >> DIGIT;
            opb_r   <= opb_r >> DIGIT;
            carry_r <= slice_co_s;
            idx_r   <= idx_r + IDXW'(1);
        end else begin
            opa_r   <= opa_r;
            opb_r   <= opb_r;
            carry_r <= carry_r;
            idx_r   <= idx_r;
        end
    end

    // Registered status and result outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
            sum_r  <= '0;
            co_r   <= 1'b0;
            ovf_r  <= 1'b0;
        end else begin
            busy_r <= (state_next_s == RUN);
            done_r <= last_s;
            if (last_s) begin
                sum_r <= part_next_s;
                co_r  <= slice_co_s;
                ovf_r <= slice_cmsb_s ^ slice_co_s;
            end else begin
                sum_r <= sum_r;
                co_r  <= co_r;
                ovf_r <= ovf_r;
            end
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.sum  = sum_r;
    assign bus.co   = co_r;
    assign bus.ovf  = ovf_r;
endmodule

// File: tb/tb_serial_adder.sv
// Directed and exhaustive checks of serial_adder at 16/4, 4/1 and 4/4.
module tb_serial_adder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    logic [15:0] prev_sum16 = 16'h0000;

    serial_adder_if #(.WIDTH(16)) bus16 ();
    serial_adder_if #(.WIDTH(4))  bus41 ();
    serial_adder_if #(.WIDTH(4))  bus44 ();

    serial_adder #(.WIDTH(16), .DIGIT(4)) u_dut16 (.clk(clk), .rst(rst), .bus(bus16));
    serial_adder #(.WIDTH(4),  .DIGIT(1)) u_dut41 (.clk(clk), .rst(rst), .bus(bus41));
    serial_adder #(.WIDTH(4),  .DIGIT(4)) u_dut44 (.clk(clk), .rst(rst), .bus(bus44));

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic op16(input string tag, input logic [15:0] ta, input logic [15:0] tbv,
                        input logic tcin, input logic tsub, input logic [15:0] es,
                        input logic eco, input logic eovf, input bit chg);
        int lat;
        int busy_n;
        @(negedge clk);
        bus16.a = ta; bus16.b = tbv; bus16.cin = tcin; bus16.sub = tsub; bus16.start = 1'b1;
        @(posedge clk); #1;
        bus16.start = 1'b0;
        lat = 0;
        busy_n = 0;
        while (bus16.done !== 1'b1 && lat < 20) begin
            if (bus16.busy === 1'b1) busy_n++;
            check_val({tag, "/hold"}, 32'(bus16.sum), 32'(prev_sum16));
            if (chg) begin
                bus16.a = ~ta; bus16.b = 16'hA5A5; bus16.cin = ~tcin; bus16.sub = ~tsub;
                bus16.start = (lat == 0 || lat == 2);
            end
            @(posedge clk); #1;
            lat++;
        end
        check_val({tag, "/lat"},  32'(lat), 32'd4);
        check_val({tag, "/busy_cycles"}, 32'(busy_n), 32'd4);
        check_val({tag, "/busy_done"}, 32'(bus16.busy), 32'd0);
        check_val({tag, "/sum"},  32'(bus16.sum), 32'(es));
        check_val({tag, "/co"},   32'(bus16.co),  32'(eco));
        check_val({tag, "/ovf"},  32'(bus16.ovf), 32'(eovf));
        prev_sum16 = es;
    endtask

    task automatic check_reset16(input string tag);
        check_val({tag, "/busy"}, 32'(bus16.busy), 32'd0);
        check_val({tag, "/done"}, 32'(bus16.done), 32'd0);
        check_val({tag, "/sum"},  32'(bus16.sum),  32'd0);
        check_val({tag, "/co"},   32'(bus16.co),   32'd0);
        check_val({tag, "/ovf"},  32'(bus16.ovf),  32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus16.start = 1'b0; bus16.a = 16'h0; bus16.b = 16'h0; bus16.cin = 1'b0; bus16.sub = 1'b0;
        bus41.start = 1'b0; bus41.a = 4'h0;  bus41.b = 4'h0;  bus41.cin = 1'b0; bus41.sub = 1'b0;
        bus44.start = 1'b0; bus44.a = 4'h0;  bus44.b = 4'h0;  bus44.cin = 1'b0; bus44.sub = 1'b0;
        #1;
        check_reset16("rst_held");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check_reset16("rst_released");

        op16("add_basic",  16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0);
        op16("add_wrap",   16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        op16("add_ovf",    16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
        op16("sub_neg",    16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
        op16("sub_ovf",    16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
        op16("sub_borrow", 16'h0005, 16'h0002, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b0);
        op16("add_cin",    16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0, 1'b0);
        op16("chg_in_run", 16'h1000, 16'h0234, 1'b0, 1'b0, 16'h1234, 1'b0, 1'b0, 1'b1);

        // Idle hold: result must not move without a new operation.
        repeat (3) @(posedge clk);
        #1;
        check_val("idle_hold", 32'(bus16.sum), 32'(prev_sum16));

        // start held high: one result every N+1 cycles.
        @(negedge clk);
        bus16.a = 16'h0F0F; bus16.b = 16'h0101; bus16.cin = 1'b0; bus16.sub = 1'b0; bus16.start = 1'b1;
        @(posedge clk); #1;
        for (int lat = 0; lat < 15; lat++) begin
            check_val("held/done", 32'(bus16.done), ((lat % 5) == 4) ? 32'd1 : 32'd0);
            check_val("held/busy", 32'(bus16.busy), ((lat % 5) != 4) ? 32'd1 : 32'd0);
            if (lat < 4) check_val("held/hold", 32'(bus16.sum), 32'(prev_sum16));
            else         check_val("held/sum",  32'(bus16.sum), 32'h1010);
            if (lat == 14) bus16.start = 1'b0;
            @(posedge clk); #1;
        end
        prev_sum16 = 16'h1010;

        // Asynchronous reset in the second RUN cycle.
        @(negedge clk);
        bus16.a = 16'hABCD; bus16.b = 16'h1111; bus16.start = 1'b1;
        @(posedge clk); #1;
        bus16.start = 1'b0;
        @(posedge clk); #1;
        check_val("mid_run/busy", 32'(bus16.busy), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_reset16("mid_run_rst");
        @(negedge clk);
        rst = 1'b0;
        prev_sum16 = 16'h0000;
        op16("after_rst", 16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0, 1'b0);

        // Exhaustive sweep on the 4-bit instances, both driven identically.
        for (int s = 0; s < 2; s++) begin
            for (int c = 0; c < 2; c++) begin
                for (int a = 0; a < 16; a++) begin
                    for (int b = 0; b < 16; b++) begin
                        int sa, sb, sr, ur, lat, lat41, lat44;
                        logic [4:0] ref_v, res41, res44;
                        logic ref_ovf, ovf41, ovf44;
                        sa = (a > 7) ? a - 16 : a;
                        sb = (b > 7) ? b - 16 : b;
                        if (s == 0) begin
                            ur = a + b + c;
                            sr = sa + sb + c;
                            ref_v = 5'(ur);
                        end else begin
                            ur = a - b - c;
                            sr = sa - sb - c;
                            ref_v = {(ur >= 0) ? 1'b1 : 1'b0, 4'(ur & 15)};
                        end
                        ref_ovf = (sr > 7 || sr < -8);
                        @(negedge clk);
                        bus41.a = 4'(a); bus41.b = 4'(b); bus41.cin = c[0]; bus41.sub = s[0]; bus41.start = 1'b1;
                        bus44.a = 4'(a); bus44.b = 4'(b); bus44.cin = c[0]; bus44.sub = s[0]; bus44.start = 1'b1;
                        @(posedge clk); #1;
                        bus41.start = 1'b0;
                        bus44.start = 1'b0;
                        lat = 0; lat41 = 99; lat44 = 99;
                        res41 = 5'h0; res44 = 5'h0; ovf41 = 1'b0; ovf44 = 1'b0;
                        while ((lat41 == 99 || lat44 == 99) && lat < 10) begin
                            if (lat44 == 99 && bus44.done === 1'b1) begin
                                lat44 = lat; res44 = {bus44.co, bus44.sum}; ovf44 = bus44.ovf;
                            end
                            if (lat41 == 99 && bus41.done === 1'b1) begin
                                lat41 = lat; res41 = {bus41.co, bus41.sum}; ovf41 = bus41.ovf;
                            end
                            if (lat41 == 99 || lat44 == 99) begin
                                @(posedge clk); #1;
                                lat++;
                            end
                        end
                        check_val("w4d1/lat", 32'(lat41), 32'd4);
                        check_val("w4d1/res", 32'(res41), 32'(ref_v));
                        check_val("w4d1/ovf", 32'(ovf41), 32'(ref_ovf));
                        check_val("w4d4/lat", 32'(lat44), 32'd1);
                        check_val("w4d4/res", 32'(res44), 32'(ref_v));
                        check_val("w4d4/ovf", 32'(ovf44), 32'(ref_ovf));
                    end
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
